// File: rtl/instr_encoder_pkg.sv
// Shared instruction encoding: opcodes, encoder request kinds/states and the word packer.
// INSTR_ENC_LI8_EN adds the LI8_HI encoder state used by the 8-bit literal expansion.
package instr_encoder_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [4:0] {
        litl = 5'h00,
        lith = 5'h01,
        movx = 5'h0E,
        incr = 5'h12,
        func = 5'h1F
    } OP;

    typedef enum logic [1:0] {
        done = 2'b11
    } functions;

    typedef enum logic [1:0] {
        RAW = 2'd0,
        LI8 = 2'd1,
        END = 2'd2,
        RSV = 2'd3
    } enc_kind;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
`ifdef INSTR_ENC_LI8_EN
        ST_LI8_HI = 2'd3,
`endif
        ST_DONE   = 2'd2
    } enc_state_e;

    function automatic logic [INSTR_W-1:0] enc_word(input OP op, input logic [3:0] arg);
        return {op, arg};
    endfunction

    localparam logic [INSTR_W-1:0] TERM_WORD = enc_word(func, {2'b00, done});

endpackage

// File: rtl/instr_encoder.sv
// Program writer: encodes symbolic requests into 9-bit words written to instruction memory.
// Latency: accept at edge n -> write strobe/address/data valid in cycle n+1; LI8 adds a second word at n+2.
// Backpressure: in_ready low outside LOAD, during the LI8_HI cycle and whenever start is high (INSTR_ENC_LI8_EN enables LI8).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_kind,
    input  logic [4:0]          in_op,
    input  logic [7:0]          in_arg,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     count
);

    localparam int DEPTH = 2**ADDR_W;
    // The last slot is always kept free so the END terminator can land.
    localparam logic [ADDR_W:0] RAW_LIM = (ADDR_W+1)'(DEPTH - 2);

    enc_state_e             state_q, state_d;
    logic [ADDR_W:0]        ptr_q, ptr_d;
    logic                   err_q, err_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0]     wr_data_q, wr_data_d;
    logic                   do_wr;
    logic [INSTR_W-1:0]     word;
    logic                   accept;

`ifdef INSTR_ENC_LI8_EN
    localparam logic [ADDR_W:0] LI8_LIM = (ADDR_W+1)'(DEPTH - 3);
    logic [3:0]             nib_q, nib_d;
`else
    logic                   unused_arg_hi;
    assign unused_arg_hi = ^in_arg[7:4];
`endif

    assign in_ready = (state_q == ST_LOAD) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        do_wr     = 1'b0;
        word      = '0;
`ifdef INSTR_ENC_LI8_EN
        nib_d     = nib_q;
`endif
        if (start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        case (enc_kind'(in_kind))
                            RAW: begin
                                if (ptr_q <= RAW_LIM) begin
                                    do_wr = 1'b1;
                                    word  = enc_word(OP'(in_op), in_arg[3:0]);
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
`ifdef INSTR_ENC_LI8_EN
                            LI8: begin
                                if (ptr_q <= LI8_LIM) begin
                                    do_wr   = 1'b1;
                                    word    = enc_word(litl, in_arg[3:0]);
                                    nib_d   = in_arg[7:4];
                                    state_d = ST_LI8_HI;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
`endif
                            END: begin
                                do_wr   = 1'b1;
                                word    = TERM_WORD;
                                state_d = ST_DONE;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
`ifdef INSTR_ENC_LI8_EN
                ST_LI8_HI: begin
                    do_wr   = 1'b1;
                    word    = enc_word(lith, nib_q);
                    state_d = ST_LOAD;
                end
`endif
                default: ;
            endcase
        end

        if (do_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[ADDR_W-1:0];
            wr_data_d = word;
            ptr_d     = ptr_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef INSTR_ENC_LI8_EN
            nib_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef INSTR_ENC_LI8_EN
            nib_q     <= nib_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign count   = ptr_q;
    assign done    = (state_q == ST_DONE);
`ifdef INSTR_ENC_LI8_EN
    assign busy    = (state_q == ST_LOAD) || (state_q == ST_LI8_HI);
`else
    assign busy    = (state_q == ST_LOAD);
`endif

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program writer for the 9-bit CPU. Accepts a stream of symbolic instruction requests over a valid/ready handshake, encodes each into 9-bit instruction words ({opcode[4:0], operand[3:0]}), expands the 8-bit literal pseudo-op into a `litl`/`lith` pair, and writes the words sequentially into instruction memory. Sits between the host/test loader and the instruction-memory write port. It is the write-side counterpart of the fetch/decode path that consumes the same opcode encoding.

## Interface
- `ADDR_W`, 8, instruction-memory address width; depth `DEPTH = 2**ADDR_W` words.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears pointer/err/count and enters LOAD.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_kind`  in  2  `enc_kind`: RAW=0, LI8=1, END=2, RSV=3.
- `in_op`  in  5  `OP` opcode (RAW only).
- `in_arg`  in  8  operand; RAW uses [3:0], LI8 uses [7:0].
- `wr_en`  out  1  memory write strobe, registered.
- `wr_addr`  out  ADDR_W  write address, registered.
- `wr_data`  out  9  instruction word, registered.
- `busy`  out  1  state is LOAD or LI8_HI.
- `done`  out  1  state is DONE.
- `err`  out  1  sticky: request dropped (overflow or illegal kind).
- `count`  out  ADDR_W+1  words written since `start`.

## Operation
- States: IDLE, LOAD, LI8_HI, DONE. Reset → IDLE; all outputs 0.
- IDLE: `in_ready`=0. `start` → LOAD, ptr=0, count=0, err=0.
- LOAD: `in_ready = !start`. On accept:
  - RAW: if ptr ≤ DEPTH-2, write {in_op, in_arg[3:0]}; stay LOAD.
  - LI8: if ptr ≤ DEPTH-3, write {`litl`, in_arg[3:0]}, latch in_arg[7:4], → LI8_HI.
  - END: write {`func`, 2'b00, `done`} = 9'h1F3; → DONE. Always fits (one slot is reserved for the terminator).
  - RAW/LI8 without room, or RSV: no write, err←1, stay LOAD.
- LI8_HI: `in_ready`=0; write {`lith`, latched nibble}; → LOAD.
- DONE: `in_ready`=0; count holds. `start` → LOAD (restart).
- `start` in any state restarts. In LI8_HI, a `start` abandons the pending `lith`.
- ptr increments by one per write. `count` equals ptr. With ptr bounded as above, ptr never wraps.
- `in_op`/operand values are not range-checked beyond kind; the opcode field passes through verbatim.

## Timing
- Accept at edge n → `wr_en`/`wr_addr`/`wr_data` valid for cycle n+1 (1-cycle latency).
- RAW throughput is 1 per cycle. LI8 occupies 2 cycles: `litl` at n+1, `lith` at n+2. `in_ready` is low during the LI8_HI cycle.
- `start` and `in_valid` in the same cycle: `start` wins and the request is not accepted.
- `done` rises in the cycle after END is accepted, together with the terminator write.
- `err` sets in the cycle after the dropped accept.
- Asynchronous `reset` mid-stream: immediate IDLE, `wr_en`=0, and any pending `lith` is lost.

## Configuration
- `INSTR_ENC_LI8_EN` defined: LI8 pseudo-op and LI8_HI state are present, as above.
- Not defined: LI8 is treated like RSV (accepted, dropped, err←1). LI8_HI and the nibble latch are removed.

## Structure
- Add to the shared instruction package:
  - `enc_kind` enum {RAW, LI8, END, RSV}.
  - Encoder state enum.
  - `INSTR_W = 9` constant.
  - A pure function `enc_word(OP, logic[3:0])`.
- Reuse the existing `OP` and `functions` enums for the opcode/terminator fields.
- No sub-module; a single module with the encoding in the package function.

## Test plan
- RAW stream: start, RAW (`movx`, 4'h6), RAW (`incr`, 4'h0), END → writes addr0=9'h0E6, addr1=9'h120, addr2=9'h1F3. `done`=1, `count`=3, `err`=0.
- LI8: start, LI8 arg 8'hA5 → addr0=9'h005, addr1=9'h01A. `in_ready` is low for exactly 1 cycle. A back-to-back RAW follows at addr2.
- Overflow (`ADDR_W`=3): 7 RAW accepted, 8th RAW → no write, `err`=1. END → writes addr7=9'h1F3, `count`=8.
- Collision/illegal: RSV kind → `err`=1, no write. `start` concurrent with `in_valid` → not accepted, ptr=0.
- Mid-op: `reset` asserted during LI8_HI → `wr_en` drops asynchronously, `lith` is never written, state IDLE. A later `start` writes from addr0.
- Macro off: LI8 arg 8'h3C → no write, `err`=1, stays LOAD.
